// File: rtl/eth_crc32_arb.sv
// eth_crc32_arb: frame-granular round-robin arbiter that shares one
// eth_crc32_gen between NREQ requesters. A requester owns the generator from
// SOP to EOP; the generator's accumulator advances every clock, so any gap,
// stray SOP or over-long packet aborts the frame and reports an error.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no owner; round-robin search over requesters showing SOP
//   ST_BUSY | grant owner streams beats to the generator, bubble-free
//   ST_WAIT | EOP forwarded; capture generator CRC and final byte count
module eth_crc32_arb #(
   parameter int NREQ      = 4,
   parameter int MAX_BEATS = 1200
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_vld,
   input  logic [NREQ-1:0]     req_sop,
   input  logic [NREQ-1:0]     req_eop,
   input  logic [NREQ*64-1:0]  req_data,
   input  logic [NREQ*3-1:0]   req_be,
   input  logic [NREQ*3-1:0]   req_offset,
   output logic [NREQ-1:0]     req_rdy,
   output logic                crc_data_vld,
   output logic                crc_data_sop,
   output logic                crc_data_eop,
   output logic [63:0]         crc_data_in,
   output logic [2:0]          crc_data_be,
   output logic [2:0]          crc_data_offset,
   input  logic [31:0]         crc_in,
   input  logic                crc_in_vld,
   output logic [NREQ-1:0]     res_vld,
   output logic [NREQ-1:0]     res_err,
   output logic [31:0]         res_crc,
   output logic [15:0]         res_bcnt,
   output logic                busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BW = $clog2(MAX_BEATS + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t          state_q;
   logic [IW-1:0]   grant_q;
   logic [IW-1:0]   rr_ptr_q;
   logic [BW-1:0]   beat_cnt_q;
   logic [15:0]     bcnt_q;
   logic [15:0]     bcnt_d;
   logic [NREQ-1:0] res_vld_q;
   logic [NREQ-1:0] res_err_q;
   logic [31:0]     res_crc_q;
   logic [15:0]     res_bcnt_q;

   logic [63:0] data_a [NREQ];
   logic [2:0]  be_a   [NREQ];
   logic [2:0]  off_a  [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign data_a[i] = req_data[64*i +: 64];
      assign be_a[i]   = req_be[3*i +: 3];
      assign off_a[i]  = req_offset[3*i +: 3];
   end

   // Beat currently offered by the grant owner
   logic        g_vld, g_sop, g_eop;
   logic [63:0] g_data;
   logic [2:0]  g_be, g_off;

   assign g_vld  = req_vld[grant_q];
   assign g_sop  = req_sop[grant_q];
   assign g_eop  = req_eop[grant_q];
   assign g_data = data_a[grant_q];
   assign g_be   = be_a[grant_q];
   assign g_off  = off_a[grant_q];

   // A first beat must be SOP and no later beat may be; XOR covers both cases.
   logic st_busy, first_beat, abort, fwd;

   assign st_busy    = (state_q == ST_BUSY);
   assign first_beat = (beat_cnt_q == '0);
   assign abort      = st_busy & (~g_vld | (first_beat ^ g_sop) |
                                  (beat_cnt_q == BW'(MAX_BEATS)));
   assign fwd        = st_busy & ~abort;

   assign crc_data_vld    = fwd;
   assign crc_data_sop    = fwd & g_sop;
   assign crc_data_eop    = fwd & g_eop;
   assign crc_data_in     = fwd ? g_data : 64'd0;
   assign crc_data_be     = fwd ? g_be : 3'd0;
   assign crc_data_offset = (fwd & g_sop) ? g_off : 3'd0;

   // Bytes carried by the forwarded beat, accumulated with 16-bit saturation
   logic [2:0]  off_eff;
   logic [3:0]  beat_bytes;
   logic [16:0] bcnt_sum;

   always_comb begin
      off_eff = g_sop ? g_off : 3'd0;
      if (g_eop && (g_be != 3'd0)) beat_bytes = {1'b0, g_be};
      else                         beat_bytes = 4'd8 - {1'b0, off_eff};
      bcnt_sum = {1'b0, bcnt_q} + {13'd0, beat_bytes};
      bcnt_d   = bcnt_sum[16] ? 16'hFFFF : bcnt_sum[15:0];
   end

   // Round-robin search for an SOP-presenting requester starting at rr_ptr
   logic [NREQ-1:0] elig;
   logic            pick_vld;
   logic [IW-1:0]   pick_idx;
   logic [IW-1:0]   pick_nxt;

   assign elig = req_vld & req_sop;

   always_comb begin
      int j;
      j        = 0;
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(rr_ptr_q) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!pick_vld && elig[j]) begin
            pick_vld = 1'b1;
            pick_idx = IW'(j);
         end
      end
      pick_nxt = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
   end

   // Only the grant owner is ready, and only while streaming
   always_comb begin
      req_rdy = '0;
      if (st_busy) req_rdy[grant_q] = 1'b1;
   end

   // Sequencer: grant, stream, collect result; result pulses last one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         bcnt_q     <= '0;
         res_vld_q  <= '0;
         res_err_q  <= '0;
         res_crc_q  <= '0;
         res_bcnt_q <= '0;
      end else begin
         res_vld_q <= '0;
         res_err_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (pick_vld) begin
                  grant_q    <= pick_idx;
                  rr_ptr_q   <= pick_nxt;
                  beat_cnt_q <= '0;
                  bcnt_q     <= '0;
                  state_q    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (abort) begin
                  res_err_q[grant_q] <= 1'b1;
                  state_q            <= ST_IDLE;
               end else begin
                  beat_cnt_q <= beat_cnt_q + BW'(1);
                  bcnt_q     <= bcnt_d;
                  if (g_eop) state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (crc_in_vld) begin
                  res_vld_q[grant_q] <= 1'b1;
                  res_crc_q          <= crc_in;
                  res_bcnt_q         <= bcnt_q;
               end else begin
                  res_err_q[grant_q] <= 1'b1;
               end
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign res_vld  = res_vld_q;
   assign res_err  = res_err_q;
   assign res_crc  = res_crc_q;
   assign res_bcnt = res_bcnt_q;
   assign busy     = (state_q != ST_IDLE);

endmodule
